// File: rtl/ygr_host_if_regs.sv
// Host register block for the CD subsystem: DATATRNS FIFO, DATASTAT, HIRQREQ/HIRQMSK, CRn. Reads return one cycle after the strobe.
// No backpressure: drops writes to a full FIFO and returns FFFF from an empty one. Define YGR_FIFO_STAT_CNT_EN to expose the fill count in DATASTAT[15:3].
module ygr_host_if_regs #(
    parameter int IRQ_W      = 14,
    parameter int CR_NUM     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   H_SEL,
    input  logic                   H_WE,
    input  logic [4:0]             H_ADDR,
    input  logic [15:0]            H_DI,
    output logic [15:0]            H_DO,
    output logic                   HIRQ,
    input  logic [IRQ_W-1:0]       D_IRQ_SET,
    input  logic                   D_DIR,
    input  logic                   D_FIFO_WE,
    input  logic [15:0]            D_FIFO_DI,
    input  logic                   D_FIFO_RE,
    output logic [15:0]            D_FIFO_DO,
    output logic                   D_FIFO_FULL,
    output logic                   D_FIFO_EMPTY,
    output logic                   CMD_STB,
    output logic [CR_NUM*16-1:0]   CR_OUT,
    input  logic                   RSP_WE,
    input  logic [CR_NUM*16-1:0]   RSP_DI
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_CR = 3'(CR_NUM - 1);

    logic                     host_rd, host_wr;
    logic                     sel_trn, sel_stat, sel_req, sel_msk, sel_cr;
    logic [4:0]               cr_off;
    logic [2:0]               cr_idx;

    logic                     dir_q;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [15:0]              mem_q [FIFO_DEPTH];
    logic                     full, empty, flush;
    logic                     push_req, pop_req, do_push, do_pop;
    logic [15:0]              push_dat;

    logic [IRQ_W-1:0]         req_q, req_d, msk_q, msk_d;
    logic                     hirq_q;
    logic                     cmd_stb_q, cmd_stb_d;
    logic [CR_NUM-1:0][15:0]  cr_q, cr_d;
    logic [15:0]              h_do_q, h_do_d, rd_dat;
    logic [12:0]              stat_cnt;

    assign host_rd  = H_SEL & ~H_WE;
    assign host_wr  = H_SEL & H_WE;
    assign sel_trn  = (H_ADDR[4:1] == 4'd0);
    assign sel_stat = (H_ADDR[4:1] == 4'd1);
    assign sel_req  = (H_ADDR[4:1] == 4'd2);
    assign sel_msk  = (H_ADDR[4:1] == 4'd3);
    assign cr_off   = H_ADDR - 5'd12;
    assign cr_idx   = cr_off[3:1];
    assign sel_cr   = (H_ADDR >= 5'd12) && (cr_off[4:1] < 4'(CR_NUM));

    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);
    assign flush = (D_DIR != dir_q);

    // The active direction picks which side pushes and which side pops.
    assign push_req = dir_q ? (host_wr & sel_trn) : D_FIFO_WE;
    assign pop_req  = dir_q ? D_FIFO_RE : (host_rd & sel_trn);
    assign push_dat = dir_q ? H_DI : D_FIFO_DI;
    assign do_pop   = pop_req & ~empty & ~flush;
    assign do_push  = push_req & (~full | do_pop) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

`ifdef YGR_FIFO_STAT_CNT_EN
    logic [31:0] cnt_wide;
    assign cnt_wide = 32'(cnt_q);
    assign stat_cnt = (cnt_wide > 32'd8191) ? 13'h1FFF : cnt_wide[12:0];
`else
    assign stat_cnt = '0;
`endif

    always_comb begin
        rd_dat = '0;
        if (sel_trn) begin
            rd_dat = (!dir_q && !empty) ? mem_q[rd_ptr_q] : 16'hFFFF;
        end else if (sel_stat) begin
            rd_dat = {stat_cnt, dir_q, full, empty};
        end else if (sel_req) begin
            rd_dat = 16'(req_q);
        end else if (sel_msk) begin
            rd_dat = 16'(msk_q);
        end else if (sel_cr) begin
            for (int k = 0; k < CR_NUM; k++) begin
                if (cr_idx == 3'(k)) rd_dat = cr_q[k];
            end
        end
    end

    // A device set always beats a host clear of the same bit.
    always_comb begin
        req_d = (req_q & ((host_wr && sel_req) ? H_DI[IRQ_W-1:0] : '1)) | D_IRQ_SET;
        if (RSP_WE) req_d[0] = 1'b1;
        msk_d = (host_wr && sel_msk) ? H_DI[IRQ_W-1:0] : msk_q;
    end

    always_comb begin
        cr_d = cr_q;
        if (host_wr && sel_cr) begin
            for (int k = 0; k < CR_NUM; k++) begin
                if (cr_idx == 3'(k)) cr_d[k] = H_DI;
            end
        end
        if (RSP_WE) cr_d = RSP_DI;
        cmd_stb_d = host_wr && sel_cr && (cr_idx == LAST_CR);
        h_do_d    = host_rd ? rd_dat : h_do_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dir_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            req_q     <= '0;
            msk_q     <= '1;
            hirq_q    <= 1'b0;
            cmd_stb_q <= 1'b0;
            cr_q      <= '0;
            h_do_q    <= '0;
        end else begin
            dir_q     <= D_DIR;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            msk_q     <= msk_d;
            hirq_q    <= |(req_q & msk_q);
            cmd_stb_q <= cmd_stb_d;
            cr_q      <= cr_d;
            h_do_q    <= h_do_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N && do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign H_DO         = h_do_q;
    assign HIRQ         = hirq_q;
    assign CMD_STB      = cmd_stb_q;
    assign CR_OUT       = cr_q;
    assign D_FIFO_DO    = mem_q[rd_ptr_q];
    assign D_FIFO_FULL  = full;
    assign D_FIFO_EMPTY = empty;

endmodule

// File: tb/tb_ygr_host_if_regs.sv
// Bench for ygr_host_if_regs: directed test-plan steps then random traffic against a queue-based model.
module tb_ygr_host_if_regs;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        H_SEL = 1'b0, H_WE = 1'b0;
    logic [4:0]  H_ADDR = '0;
    logic [15:0] H_DI = '0;
    logic [15:0] H_DO;
    logic        HIRQ;
    logic [13:0] D_IRQ_SET = '0;
    logic        D_DIR = 1'b0, D_FIFO_WE = 1'b0, D_FIFO_RE = 1'b0;
    logic [15:0] D_FIFO_DI = '0;
    logic [15:0] D_FIFO_DO;
    logic        D_FIFO_FULL, D_FIFO_EMPTY, CMD_STB;
    logic [63:0] CR_OUT;
    logic        RSP_WE = 1'b0;
    logic [63:0] RSP_DI = '0;

    ygr_host_if_regs dut (
        .CLK(CLK), .RST_N(RST_N), .H_SEL(H_SEL), .H_WE(H_WE), .H_ADDR(H_ADDR),
        .H_DI(H_DI), .H_DO(H_DO), .HIRQ(HIRQ), .D_IRQ_SET(D_IRQ_SET), .D_DIR(D_DIR),
        .D_FIFO_WE(D_FIFO_WE), .D_FIFO_DI(D_FIFO_DI), .D_FIFO_RE(D_FIFO_RE),
        .D_FIFO_DO(D_FIFO_DO), .D_FIFO_FULL(D_FIFO_FULL), .D_FIFO_EMPTY(D_FIFO_EMPTY),
        .CMD_STB(CMD_STB), .CR_OUT(CR_OUT), .RSP_WE(RSP_WE), .RSP_DI(RSP_DI)
    );

    always #5 CLK = ~CLK;

`ifdef YGR_FIFO_STAT_CNT_EN
    localparam logic [15:0] STAT_FULL16 = 16'h0082;
`else
    localparam logic [15:0] STAT_FULL16 = 16'h0002;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] mq[$];
    logic        mdir = 1'b0;
    logic [15:0] mreq = '0, mmsk = 16'h3FFF, mhdo = '0;
    logic        mhirq = 1'b0, mstb = 1'b0;
    logic [15:0] mcr [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] stat_model();
        logic [12:0] c = '0;
`ifdef YGR_FIFO_STAT_CNT_EN
        c = 13'(mq.size());
`endif
        return {c, mdir, mq.size() == 16, mq.size() == 0};
    endfunction

    function automatic logic [15:0] rd_model(input logic [4:0] a);
        if (a < 2)  return (!mdir && mq.size() > 0) ? mq[0] : 16'hFFFF;
        if (a < 4)  return stat_model();
        if (a < 6)  return mreq;
        if (a < 8)  return mmsk;
        if (a >= 12 && a < 20) return mcr[(a - 12) >> 1];
        return 16'h0000;
    endfunction

    // Advance one clock with the currently driven inputs, update the model, compare every output.
    task automatic cycle();
        logic hrd, hwr, pop, push;
        logic [15:0] pdat;
        int sz;
        hrd = H_SEL && !H_WE;
        hwr = H_SEL && H_WE;
        if (!RST_N) begin
            mq.delete();
            mdir = 1'b0; mreq = '0; mmsk = 16'h3FFF; mhdo = '0; mhirq = 1'b0; mstb = 1'b0;
            for (int k = 0; k < 4; k++) mcr[k] = '0;
        end else begin
            if (hrd) mhdo = rd_model(H_ADDR);
            mhirq = |(mreq & mmsk);
            mstb  = hwr && (H_ADDR == 5'd18 || H_ADDR == 5'd19);
            sz = mq.size();
            if (D_DIR != mdir) begin
                mq.delete();
            end else begin
                if (!mdir) begin
                    pop  = hrd && H_ADDR < 2 && sz > 0;
                    push = D_FIFO_WE && (sz < 16 || pop);
                    pdat = D_FIFO_DI;
                end else begin
                    pop  = D_FIFO_RE && sz > 0;
                    push = hwr && H_ADDR < 2 && (sz < 16 || pop);
                    pdat = H_DI;
                end
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(pdat);
            end
            mdir = D_DIR;
            mreq = ((mreq & ((hwr && (H_ADDR == 4 || H_ADDR == 5)) ? H_DI : 16'hFFFF))
                    | 16'(D_IRQ_SET)) & 16'h3FFF;
            if (RSP_WE) mreq[0] = 1'b1;
            if (hwr && (H_ADDR == 6 || H_ADDR == 7)) mmsk = H_DI & 16'h3FFF;
            if (hwr && H_ADDR >= 12 && H_ADDR < 20) mcr[(H_ADDR - 12) >> 1] = H_DI;
            if (RSP_WE) for (int k = 0; k < 4; k++) mcr[k] = RSP_DI[16*k +: 16];
        end
        @(posedge CLK);
        #1;
        chk("h_do", H_DO, mhdo);
        chk("hirq", HIRQ, mhirq);
        chk("cmd_stb", CMD_STB, mstb);
        chk("cr_out", CR_OUT, {mcr[3], mcr[2], mcr[1], mcr[0]});
        chk("fifo_empty", D_FIFO_EMPTY, mq.size() == 0);
        chk("fifo_full", D_FIFO_FULL, mq.size() == 16);
        if (mq.size() > 0) chk("fifo_do", D_FIFO_DO, mq[0]);
    endtask

    task automatic host_wr(input logic [4:0] a, input logic [15:0] d);
        H_SEL = 1'b1; H_WE = 1'b1; H_ADDR = a; H_DI = d;
        cycle();
        H_SEL = 1'b0; H_WE = 1'b0;
    endtask

    task automatic host_rd(input logic [4:0] a, output logic [15:0] d);
        H_SEL = 1'b1; H_WE = 1'b0; H_ADDR = a;
        cycle();
        d = H_DO;
        H_SEL = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] words [16];

        // Reset
        cycle();
        cycle();
        RST_N = 1'b1;
        chk("rst_hirq", HIRQ, 1'b0);
        chk("rst_empty", D_FIFO_EMPTY, 1'b1);
        host_rd(5'd4, d);  chk("rst_hirqreq", d, 16'h0000);
        host_rd(5'd6, d);  chk("rst_hirqmsk", d, 16'h3FFF);
        host_rd(5'd2, d);  chk("rst_datastat", d, 16'h0001);

        // Interrupt set/clear race
        host_wr(5'd6, 16'h0004);
        D_IRQ_SET = 14'h0004;
        cycle();
        D_IRQ_SET = '0;
        chk("irq_not_yet", HIRQ, 1'b0);
        cycle();
        chk("irq_rise", HIRQ, 1'b1);
        D_IRQ_SET = 14'h0004;
        host_wr(5'd4, 16'hFFFB);
        D_IRQ_SET = '0;
        host_rd(5'd4, d);  chk("irq_race_keep", d, 16'h0004);
        host_wr(5'd4, 16'hFFFB);
        chk("irq_hold_one", HIRQ, 1'b1);
        cycle();
        chk("irq_drop", HIRQ, 1'b0);

        // Device-to-host fill, overflow drop, drain with underflow
        for (int i = 0; i < 17; i++) begin
            D_FIFO_WE = 1'b1; D_FIFO_DI = 16'h1000 + 16'(i);
            cycle();
        end
        D_FIFO_WE = 1'b0;
        host_rd(5'd2, d);  chk("fill_stat", d, STAT_FULL16);
        for (int i = 0; i < 17; i++) begin
            host_rd(5'd0, d);
            chk("drain", d, (i < 16) ? 64'(16'h1000 + 16'(i)) : 64'hFFFF);
        end
        host_rd(5'd2, d);  chk("drain_stat", d, 16'h0001);

        // Direction flush
        for (int i = 0; i < 5; i++) begin
            D_FIFO_WE = 1'b1; D_FIFO_DI = 16'h2000 + 16'(i);
            cycle();
        end
        D_FIFO_WE = 1'b0;
        D_DIR = 1'b1;
        cycle();
        chk("flush_empty", D_FIFO_EMPTY, 1'b1);
        host_rd(5'd2, d);  chk("flush_stat", d, 16'h0005);
        host_rd(5'd0, d);  chk("dir1_read", d, 16'hFFFF);
        host_wr(5'd0, 16'hABCD);
        chk("h2d_head", D_FIFO_DO, 16'hABCD);
        D_FIFO_RE = 1'b1;
        cycle();
        D_FIFO_RE = 1'b0;
        chk("h2d_popped", D_FIFO_EMPTY, 1'b1);

        // Command and response
        host_wr(5'd12, 16'h0100); chk("stb_cr0", CMD_STB, 1'b0);
        host_wr(5'd14, 16'h0200);
        host_wr(5'd16, 16'h0300); chk("stb_cr2", CMD_STB, 1'b0);
        host_wr(5'd18, 16'h0400); chk("stb_cr3", CMD_STB, 1'b1);
        chk("cr_words", CR_OUT, 64'h0400_0300_0200_0100);
        cycle();
        chk("stb_once", CMD_STB, 1'b0);
        RSP_DI = 64'h4444_3333_2222_DEAD; RSP_WE = 1'b1;
        cycle();
        RSP_WE = 1'b0;
        host_rd(5'd12, d); chk("rsp_cr0", d, 16'hDEAD);
        host_rd(5'd4, d);  chk("rsp_cmok", d[0], 1'b1);
        RSP_DI = 64'h1111_2222_3333_4444; RSP_WE = 1'b1;
        host_wr(5'd19, 16'h5555);
        RSP_WE = 1'b0;
        chk("rsp_wins", CR_OUT, 64'h1111_2222_3333_4444);
        chk("rsp_stb", CMD_STB, 1'b1);

        // Simultaneous pop and push while full
        D_DIR = 1'b0;
        cycle();
        for (int i = 0; i < 16; i++) begin
            words[i] = 16'($urandom);
            D_FIFO_WE = 1'b1; D_FIFO_DI = words[i];
            cycle();
        end
        D_FIFO_DI = 16'hBEEF;
        host_rd(5'd0, d);
        D_FIFO_WE = 1'b0;
        chk("full_pop_push_head", d, words[0]);
        chk("full_pop_push_full", D_FIFO_FULL, 1'b1);
        host_rd(5'd2, d);  chk("full_pop_push_stat", d, STAT_FULL16);
        for (int i = 1; i < 17; i++) begin
            host_rd(5'd0, d);
            chk("full_order", d, (i < 16) ? 64'(words[i]) : 64'hBEEF);
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) D_DIR = ~D_DIR;
            H_SEL     = 1'($urandom_range(0, 1));
            H_WE      = 1'($urandom_range(0, 1));
            H_ADDR    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
            H_DI      = 16'($urandom);
            D_IRQ_SET = ($urandom_range(0, 7) == 0) ? 14'(1 << $urandom_range(0, 13)) : 14'h0;
            D_FIFO_WE = 1'($urandom_range(0, 1));
            D_FIFO_RE = 1'($urandom_range(0, 1));
            D_FIFO_DI = 16'($urandom);
            RSP_WE    = ($urandom_range(0, 29) == 0);
            RSP_DI    = {$urandom, $urandom};
            RST_N     = ($urandom_range(0, 199) != 0);
            cycle();
        end
        RST_N = 1'b1; H_SEL = 1'b0; D_FIFO_WE = 1'b0; D_FIFO_RE = 1'b0;
        D_IRQ_SET = '0; RSP_WE = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ygr_host_if_regs.md
Name: ygr_host_if_regs

Overview:
- Parametrised host-side register block for the CD subsystem. It implements DATATRNS (backed by a data FIFO), DATASTAT, HIRQREQ, HIRQMSK and CRn.
- The SH-2 host and the CD-block device side both access it.
- It generalises the fixed register set:
  - configurable IRQ bit count, command-register count and data FIFO depth;
  - direction-switched FIFO with flush;
  - command strobe and response load;
  - masked interrupt output.

Parameters:
- IRQ_W, 14: number of implemented HIRQREQ/HIRQMSK bits (1..16); upper bits read 0.
- CR_NUM, 4: number of 16-bit command/response registers (1..8).
- FIFO_DEPTH, 16: DATATRNS FIFO entries; power of 2, minimum 2.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- H_SEL  in  1  host access strobe, one cycle per access
- H_WE  in  1  1 = write, 0 = read
- H_ADDR  in  5  word index (byte offset >> 1)
- H_DI  in  16  host write data
- H_DO  out  16  host read data
- HIRQ  out  1  host interrupt
- D_IRQ_SET  in  IRQ_W  device IRQ set pulses, one bit each
- D_DIR  in  1  FIFO direction: 0 = device->host, 1 = host->device
- D_FIFO_WE  in  1  device push (honoured only when D_DIR=0)
- D_FIFO_DI  in  16  device push data
- D_FIFO_RE  in  1  device pop (honoured only when D_DIR=1)
- D_FIFO_DO  out  16  FIFO head word, combinational
- D_FIFO_FULL  out  1  FIFO full
- D_FIFO_EMPTY  out  1  FIFO empty
- CMD_STB  out  1  command issued pulse
- CR_OUT  out  CR_NUM*16  current CR contents, CR0 in the low word
- RSP_WE  in  1  device response load
- RSP_DI  in  CR_NUM*16  response words

Behaviour:
- Clock and reset: single clock, CLK. RST_N is synchronous and active-low; it is sampled on the CLK rising edge and overrides all other activity.
- Reset values:
  - H_DO = 0, HIRQ = 0, CMD_STB = 0, CR all 0.
  - HIRQREQ = 0; HIRQMSK = all IRQ_W bits 1.
  - FIFO empty, so D_FIFO_EMPTY = 1 and D_FIFO_FULL = 0.
  - The internal DIR register is 0.
- Address map (word index):
  - 0,1 DATATRNS.
  - 2,3 DATASTAT.
  - 4,5 HIRQREQ.
  - 6,7 HIRQMSK.
  - CRk at 12+2k and 13+2k, for k < CR_NUM.
  - All other indices read 0 and ignore writes.
- Reads: H_DO is registered and valid the cycle after H_SEL=1 with H_WE=0. It holds its value when there is no read.
- DATASTAT value: {13'b0, DIR, FUL, EMP}.
- DATATRNS read:
  - When DIR=0 and the FIFO is non-empty: return the head and pop.
  - When empty, or when DIR=1: return 16'hFFFF and leave the FIFO unchanged.
- DATATRNS write:
  - When DIR=1 and not full: push H_DI.
  - Otherwise: drop the write.
- FIFO pointers and count:
  - Pointers wrap modulo FIFO_DEPTH.
  - The count spans 0..FIFO_DEPTH.
  - FUL = (count == FIFO_DEPTH); EMP = (count == 0).
  - A push and a pop in the same cycle leave the count unchanged. This is legal even when the FIFO is full or empty: a pop on empty is ignored, so a push-only applies.
- Direction change: the internal DIR register samples D_DIR each cycle. When a sampled change occurs, the FIFO is flushed in that cycle (pointers and count cleared), and any push or pop in that cycle is discarded.
- HIRQREQ:
  - The next value is (REQ & (host write ? H_DI : all ones)) | D_IRQ_SET.
  - Host writes 0 to clear a bit; writing 1 has no effect.
  - A device set and a host clear of the same bit in the same cycle leave the bit set.
  - RSP_WE additionally sets bit 0 (CMOK).
- HIRQMSK: plain read/write register, masked to IRQ_W bits.
- HIRQ: registered |(HIRQREQ & HIRQMSK). It reflects any change one cycle after that change.
- CR registers:
  - A host write to either word of CRk stores H_DI.
  - A host write to CR(CR_NUM-1) pulses CMD_STB for exactly one cycle, in the cycle after the write.
  - RSP_WE loads every CRk from RSP_DI.
  - A simultaneous host CR write and RSP_WE: RSP_WE wins, and CMD_STB still fires if the host wrote the last CR.

Optional Feature:
- Macro: YGR_FIFO_STAT_CNT_EN.
- Defined: DATASTAT[15:3] reports the FIFO fill count, zero-extended and saturating at 13 bits.
- Undefined: DATASTAT[15:3] reads 0, and no count mirror logic is generated.

Test Plan:
- Reset check: hold RST_N low for 2 cycles, then read words 4 and 6.
  - Required: 0x0000 and 0x3FFF; HIRQ = 0; DATASTAT = 0x0001.
- Interrupt set/clear race:
  - D_IRQ_SET = 0x0004 with HIRQMSK = 0x0004: HIRQ rises 2 cycles later.
  - Host writes 0xFFFB to HIRQREQ while D_IRQ_SET = 0x0004 again: bit 2 stays set.
  - A later clear alone drops HIRQ one cycle after HIRQREQ clears.
- Device-to-host fill:
  - With D_DIR=0, push 16 words 0x1000..0x100F: DATASTAT = 0x0002; a 17th push is dropped.
  - 17 host reads return 0x1000..0x100F, then 0xFFFF; DATASTAT = 0x0001.
- Direction flush: with 5 words queued, toggle D_DIR to 1.
  - Required: EMP = 1 next cycle and DIR reads 1.
  - Host writes 0xABCD, device pop returns 0xABCD.
- Command and response:
  - Host writes CR0..CR3 = 0x0100, 0x0200, 0x0300, 0x0400: CMD_STB pulses once, and CR_OUT = 0x0400_0300_0200_0100.
  - RSP_WE with 0xDEAD in CR0: host reads 0xDEAD at word 12, and HIRQREQ bit 0 = 1.
- Simultaneous FIFO traffic: with the FIFO full, issue a host pop and a device push in the same cycle.
  - Required: count stays 16, and the order is preserved.
  - With YGR_FIFO_STAT_CNT_EN defined, DATASTAT = 0x0082.
